// File: rtl/legv8_multicycle_ctrl_if.sv
// Memory-side bundle between legv8_multicycle_ctrl (master) and the instruction/data memories (slave).
// Handshake: req stays high from state entry through the ack cycle; ack counts only while req is high.
interface legv8_multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instr_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, instr_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, instr_rdata, dmem_ack
    );
endinterface

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 sequencer: owns PC/IR, drives per-phase datapath controls and memory req/ack.
// Optional memory watchdog enabled by defining MC_WATCHDOG_EN.
module legv8_multicycle_ctrl #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    MEM_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    legv8_multicycle_ctrl_if.master mem_if,
    input  logic                  i_zero,
    input  logic [DATA_WIDTH-1:0] i_branch_target,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [31:0]           o_ir,
    output logic                  o_reg_to_loc,
    output logic                  o_alu_src,
    output logic                  o_mem_to_reg,
    output logic                  o_reg_write,
    output logic [1:0]            o_alu_op,
    output logic                  o_halted,
    output logic                  o_fault,
    output logic [31:0]           o_instr_count,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [31:0]           r_ir;
    logic [31:0]           r_count;
    logic                  w_ir_load;
    logic                  w_pc_step;
    logic                  w_pc_branch;
    logic                  w_retire;
    logic                  w_timeout;

    logic [10:0] w_op;
    logic        w_is_r;
    logic        w_is_ldur;
    logic        w_is_stur;
    logic        w_is_cbz;
    logic        w_is_halt;
    logic        w_active;

    assign w_op      = r_ir[31:21];
    assign w_is_r    = (w_op == 11'b10001011000) || (w_op == 11'b11001011000) ||
                       (w_op == 11'b10001010000) || (w_op == 11'b10101010000);
    assign w_is_ldur = (w_op == 11'b11111000010);
    assign w_is_stur = (w_op == 11'b11111000000);
    assign w_is_cbz  = (r_ir[31:24] == 8'b10110100);
    assign w_is_halt = (r_ir == 32'h0);
    assign w_active  = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                       (r_state == S_MEM)    || (r_state == S_WB);

`ifdef MC_WATCHDOG_EN
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    logic [WD_W-1:0] r_wait;

    // Clears whenever the state changes, so each FETCH/MEM visit starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset || (w_next != r_state)) begin
            r_wait <= '0;
        end else if (((r_state == S_FETCH) && !mem_if.imem_ack) ||
                     ((r_state == S_MEM) && !mem_if.dmem_ack)) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign w_timeout = (r_wait == WD_W'(MEM_TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            if (w_ir_load) begin
                r_ir <= mem_if.instr_rdata;
            end
            if (w_pc_branch) begin
                r_pc <= i_branch_target;
            end else if (w_pc_step) begin
                r_pc <= r_pc + DATA_WIDTH'(4);
            end
            if (w_retire) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Everything combinational is forced low during reset so a pending req drops immediately.
    always_comb begin
        w_next          = r_state;
        w_ir_load       = 1'b0;
        w_pc_step       = 1'b0;
        w_pc_branch     = 1'b0;
        w_retire        = 1'b0;
        mem_if.imem_req = 1'b0;
        mem_if.dmem_req = 1'b0;
        mem_if.dmem_we  = 1'b0;
        o_reg_to_loc    = 1'b0;
        o_alu_src       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_op        = 2'b00;
        o_halted        = 1'b0;
        o_fault         = 1'b0;
        if (!i_reset) begin
            if (w_active) begin
                o_reg_to_loc = w_is_stur || w_is_cbz;
                o_alu_src    = w_is_ldur || w_is_stur;
                o_alu_op     = w_is_r ? 2'b10 : (w_is_cbz ? 2'b01 : 2'b00);
            end
            case (r_state)
                S_FETCH: begin
                    mem_if.imem_req = 1'b1;
                    if (mem_if.imem_ack) begin
                        w_ir_load = 1'b1;
                        w_next    = S_DECODE;
                    end else if (w_timeout) begin
                        w_next = S_FAULT;
                    end
                end
                S_DECODE: begin
                    if (w_is_halt) begin
                        w_next = S_HALT;
                    end else if (w_is_r || w_is_ldur || w_is_stur || w_is_cbz) begin
                        w_next = S_EXEC;
                    end else begin
                        w_next = S_FAULT;
                    end
                end
                S_EXEC: begin
                    if (w_is_cbz) begin
                        w_pc_branch = i_zero;
                        w_pc_step   = !i_zero;
                        w_retire    = 1'b1;
                        w_next      = S_FETCH;
                    end else if (w_is_r) begin
                        w_next = S_WB;
                    end else begin
                        w_next = S_MEM;
                    end
                end
                S_MEM: begin
                    mem_if.dmem_req = 1'b1;
                    mem_if.dmem_we  = w_is_stur;
                    if (mem_if.dmem_ack) begin
                        if (w_is_stur) begin
                            w_pc_step = 1'b1;
                            w_retire  = 1'b1;
                            w_next    = S_FETCH;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_timeout) begin
                        w_next = S_FAULT;
                    end
                end
                S_WB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = w_is_ldur;
                    w_pc_step    = 1'b1;
                    w_retire     = 1'b1;
                    w_next       = S_FETCH;
                end
                S_HALT:  o_halted = 1'b1;
                S_FAULT: o_fault  = 1'b1;
                default: w_next = S_FAULT;
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_ir          = r_ir;
    assign o_instr_count = r_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: single-instruction vector table plus multi-cycle sequences.
// Memories are modelled by a negedge responder with configurable wait counts.
module tb_legv8_multicycle_ctrl;
    localparam int          DW  = 64;
    localparam logic [63:0] RPC = 64'h1000;

    localparam logic [31:0] I_ADD  = {11'b10001011000, 21'h00423};
    localparam logic [31:0] I_SUB  = {11'b11001011000, 21'h01085};
    localparam logic [31:0] I_AND  = {11'b10001010000, 21'h00c41};
    localparam logic [31:0] I_ORR  = {11'b10101010000, 21'h00862};
    localparam logic [31:0] I_LDUR = {11'b11111000010, 21'h00101};
    localparam logic [31:0] I_STUR = {11'b11111000000, 21'h00202};
    localparam logic [31:0] I_CBZ  = {8'b10110100, 24'h000103};

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_MEM   = 3'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    legv8_multicycle_ctrl_if mif();

    logic          zero = 1'b0;
    logic [DW-1:0] target = '0;
    logic [DW-1:0] o_pc;
    logic [31:0]   o_ir;
    logic          o_reg_to_loc, o_alu_src, o_mem_to_reg, o_reg_write;
    logic [1:0]    o_alu_op;
    logic          o_halted, o_fault;
    logic [31:0]   o_instr_count;
    logic [2:0]    o_state;

    legv8_multicycle_ctrl #(.DATA_WIDTH(DW), .RESET_PC(RPC), .MEM_TIMEOUT(15)) dut (
        .i_clk(clk), .i_reset(rst), .mem_if(mif),
        .i_zero(zero), .i_branch_target(target),
        .o_pc(o_pc), .o_ir(o_ir), .o_reg_to_loc(o_reg_to_loc), .o_alu_src(o_alu_src),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_alu_op(o_alu_op),
        .o_halted(o_halted), .o_fault(o_fault), .o_instr_count(o_instr_count), .o_state(o_state)
    );

    logic [31:0] prog [16];
    int  imem_wait = 0, dmem_wait = 0;
    bit  i_never = 0, d_never = 0, force_dack = 0;
    int  iw_cnt = 0, dw_cnt = 0;
    int  mon_rw = 0, mon_m2r = 0, mon_dreq = 0, mon_dwe = 0, mon_ireq = 0;
    logic [1:0] cap_aluop = '0;
    logic cap_src = 1'b0, cap_r2l = 1'b0;

    // Memory responder and output monitor, both mid-cycle.
    always @(negedge clk) begin
        if (mif.imem_req && !i_never && iw_cnt >= imem_wait) begin
            mif.imem_ack    = 1'b1;
            mif.instr_rdata = prog[o_pc[5:2]];
            iw_cnt          = 0;
        end else begin
            mif.imem_ack    = 1'b0;
            mif.instr_rdata = 32'hDEAD_BEEF;
            iw_cnt          = mif.imem_req ? iw_cnt + 1 : 0;
        end
        if (mif.dmem_req && !d_never && dw_cnt >= dmem_wait) begin
            mif.dmem_ack = 1'b1;
            dw_cnt       = 0;
        end else begin
            mif.dmem_ack = force_dack;
            dw_cnt       = mif.dmem_req ? dw_cnt + 1 : 0;
        end
        mon_rw   += int'(o_reg_write);
        mon_m2r  += int'(o_mem_to_reg);
        mon_dreq += int'(mif.dmem_req);
        mon_dwe  += int'(mif.dmem_we);
        mon_ireq += int'(mif.imem_req);
        if (o_state == 3'd2) begin
            cap_aluop = o_alu_op;
            cap_src   = o_alu_src;
            cap_r2l   = o_reg_to_loc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_pc", o_pc, RPC);
        check("rst_ir", o_ir, 0);
        check("rst_count", o_instr_count, 0);
        check("rst_state", o_state, ST_FETCH);
        check("rst_imem_req", mif.imem_req, 0);
        check("rst_dmem_req", mif.dmem_req, 0);
        check("rst_reg_write", o_reg_write, 0);
        check("rst_halted_fault", {o_halted, o_fault}, 0);
        rst = 1'b0;
    endtask

    // sel: 0 = instr_count reaches tgt, 1 = halted, 2 = fault, 3 = state is MEM
    task automatic wait_for(input int sel, input int tgt, input int budget, output int edges);
        bit done;
        done  = 0;
        edges = 0;
        while (!done && edges < budget) begin
            @(posedge clk); #1;
            edges++;
            case (sel)
                0: done = (o_instr_count == 32'(tgt));
                1: done = o_halted;
                2: done = o_fault;
                default: done = (o_state == ST_MEM);
            endcase
        end
        check($sformatf("wait_done_sel%0d", sel), done, 1);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        z;
        logic [63:0] tgt;
        int          iw, dw;
        int          cycles;
        logic [63:0] pc;
        int          rw, m2r, dreq, dwe;
        logic [1:0]  aluop;
        logic        src, r2l;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int edges, rw0, m2r0, dreq0, dwe0, ireq0;

        vecs[0] = '{I_ADD,  0, 64'h0,  0, 0, 4, RPC + 4, 1, 0, 0, 0, 2'b10, 0, 0};
        vecs[1] = '{I_SUB,  0, 64'h0,  2, 0, 6, RPC + 4, 1, 0, 0, 0, 2'b10, 0, 0};
        vecs[2] = '{I_AND,  0, 64'h0,  0, 0, 4, RPC + 4, 1, 0, 0, 0, 2'b10, 0, 0};
        vecs[3] = '{I_ORR,  0, 64'h0,  1, 0, 5, RPC + 4, 1, 0, 0, 0, 2'b10, 0, 0};
        vecs[4] = '{I_LDUR, 0, 64'h0,  0, 0, 5, RPC + 4, 1, 1, 1, 0, 2'b00, 1, 0};
        vecs[5] = '{I_LDUR, 0, 64'h0,  0, 3, 8, RPC + 4, 1, 1, 4, 0, 2'b00, 1, 0};
        vecs[6] = '{I_STUR, 0, 64'h0,  0, 0, 4, RPC + 4, 0, 0, 1, 1, 2'b00, 1, 1};
        vecs[7] = '{I_STUR, 0, 64'h0,  1, 2, 7, RPC + 4, 0, 0, 3, 3, 2'b00, 1, 1};
        vecs[8] = '{I_CBZ,  1, 64'h40, 0, 0, 3, 64'h40,  0, 0, 0, 0, 2'b01, 0, 1};
        vecs[9] = '{I_CBZ,  0, 64'h40, 0, 0, 3, RPC + 4, 0, 0, 0, 0, 2'b01, 0, 1};

        mif.imem_ack    = 1'b0;
        mif.dmem_ack    = 1'b0;
        mif.instr_rdata = '0;
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;

        for (int v = 0; v < 10; v++) begin
            prog[0]   = vecs[v].instr;
            prog[1]   = 32'h0;
            zero      = vecs[v].z;
            target    = vecs[v].tgt;
            imem_wait = vecs[v].iw;
            dmem_wait = vecs[v].dw;
            do_reset();
            rw0 = mon_rw; m2r0 = mon_m2r; dreq0 = mon_dreq; dwe0 = mon_dwe;
            wait_for(0, 1, 40, edges);
            check($sformatf("v%0d_cycles", v), 64'(edges), 64'(vecs[v].cycles));
            check($sformatf("v%0d_pc", v), o_pc, vecs[v].pc);
            check($sformatf("v%0d_ir", v), o_ir, vecs[v].instr);
            check($sformatf("v%0d_reg_write", v), 64'(mon_rw - rw0), 64'(vecs[v].rw));
            check($sformatf("v%0d_mem_to_reg", v), 64'(mon_m2r - m2r0), 64'(vecs[v].m2r));
            check($sformatf("v%0d_dmem_req", v), 64'(mon_dreq - dreq0), 64'(vecs[v].dreq));
            check($sformatf("v%0d_dmem_we", v), 64'(mon_dwe - dwe0), 64'(vecs[v].dwe));
            check($sformatf("v%0d_exec_ctrl", v), {cap_aluop, cap_src, cap_r2l},
                  {vecs[v].aluop, vecs[v].src, vecs[v].r2l});
        end

        // ADD, SUB, ORR, HALT with zero-wait memories.
        prog[0] = I_ADD; prog[1] = I_SUB; prog[2] = I_ORR; prog[3] = 32'h0;
        imem_wait = 0; dmem_wait = 0;
        do_reset();
        rw0 = mon_rw;
        for (int k = 1; k <= 3; k++) begin
            wait_for(0, k, 20, edges);
            check($sformatf("prog_spacing_%0d", k), 64'(edges), 4);
        end
        wait_for(1, 0, 20, edges);
        check("prog_halt_cycles", 64'(edges), 2);
        check("prog_count", o_instr_count, 3);
        check("prog_pc", o_pc, RPC + 12);
        check("prog_reg_write", 64'(mon_rw - rw0), 3);
        ireq0 = mon_ireq;
        repeat (6) @(posedge clk);
        #1;
        check("halt_no_req", 64'(mon_ireq - ireq0), 0);
        check("halt_held", {o_halted, o_fault}, 2'b10);

        // Illegal encoding.
        prog[0] = 32'hFFFF_FFFF;
        do_reset();
        wait_for(2, 0, 20, edges);
        check("illegal_cycles", 64'(edges), 2);
        ireq0 = mon_ireq; dreq0 = mon_dreq;
        repeat (5) @(posedge clk);
        #1;
        check("fault_no_req", 64'(mon_ireq - ireq0 + mon_dreq - dreq0), 0);
        check("fault_count", o_instr_count, 0);
        check("fault_held", {o_halted, o_fault}, 2'b01);

        // CBZ to the top of the address space, then pc+4 wraps to zero.
        prog[0] = I_CBZ; prog[15] = I_ADD;
        zero = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        do_reset();
        wait_for(0, 1, 20, edges);
        check("wrap_cbz_pc", o_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_for(0, 2, 20, edges);
        check("wrap_add_cycles", 64'(edges), 4);
        check("wrap_pc", o_pc, 64'h0);
        prog[15] = 32'h0;

        // Reset during a pending STUR data request, with an ack in the reset cycle.
        prog[0] = I_STUR; zero = 1'b0; d_never = 1;
        do_reset();
        wait_for(3, 0, 20, edges);
        check("stur_mem_entry", 64'(edges), 3);
        @(posedge clk); #1;
        check("stur_req_held", {mif.dmem_req, mif.dmem_we}, 2'b11);
        rw0 = mon_rw;
        rst = 1'b1; force_dack = 1;
        @(posedge clk); #1;
        check("abort_state", o_state, ST_FETCH);
        check("abort_pc", o_pc, RPC);
        check("abort_ir", o_ir, 0);
        check("abort_count", o_instr_count, 0);
        check("abort_reg_write", 64'(mon_rw - rw0), 0);
        check("abort_dmem_req", mif.dmem_req, 0);
        rst = 1'b0; force_dack = 0; d_never = 0;
        #1;
        check("refetch_req", mif.imem_req, 1);
        check("refetch_pc", o_pc, RPC);
        wait_for(0, 1, 20, edges);
        check("refetch_cycles", 64'(edges), 4);
        check("refetch_pc_after", o_pc, RPC + 4);

`ifdef MC_WATCHDOG_EN
        prog[0] = I_ADD; i_never = 1;
        do_reset();
        wait_for(2, 0, 40, edges);
        check("wd_fault_cycles", 64'(edges), 16);
        check("wd_fault_count", o_instr_count, 0);
        i_never = 0; imem_wait = 15;
        do_reset();
        wait_for(0, 1, 60, edges);
        check("wd_ack_wins_cycles", 64'(edges), 19);
        check("wd_ack_wins_fault", o_fault, 0);
        imem_wait = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/legv8_multicycle_ctrl.md
# legv8_multicycle_ctrl

Multi-cycle sequencer for the LEGv8 datapath. It replaces single-cycle control with a state machine that holds the PC and instruction register and drives per-phase datapath controls. It talks to instruction and data memory through req/ack handshakes, so memories may take any number of cycles to respond. The block sits between the memories and the existing register bank, ALU, ALU control and multiplexors.

## Interface
- DATA_WIDTH, 64, width of the PC and the branch target.
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, maximum number of wait cycles without ack before a fault (watchdog builds only).
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- imem_req  out  1  fetch request.
- imem_ack  in  1  fetch complete; instr_rdata valid in the same cycle.
- instr_rdata  in  32  fetched instruction word.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store (STUR), 0 = load (LDUR).
- dmem_ack  in  1  data access complete.
- zero  in  1  ALU zero flag.
- branch_target  in  DATA_WIDTH  pc + (sign-extended offset << 2), computed outside the block.
- pc  out  DATA_WIDTH  current PC.
- ir  out  32  latched instruction.
- reg_to_loc, alu_src, mem_to_reg, reg_write  out  1 each  datapath controls.
- alu_op  out  2  00 = add (mem), 01 = pass/zero-test (CBZ), 10 = R-type.
- halted  out  1  HALT reached.
- fault  out  1  illegal opcode, or watchdog expiry.
- instr_count  out  32  number of retired instructions.

## Operation
- Decode uses ir[31:21]:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: R-type.
  - LDUR 11111000010, STUR 11111000000.
  - CBZ: ir[31:24] = 10110100.
  - ir = 32'h0 means HALT.
  - Any other encoding is illegal.
- States and transitions:
  - FETCH: imem_req=1. On imem_ack, ir <= instr_rdata and go to DECODE.
  - DECODE: HALT encoding goes to HALT; illegal goes to FAULT; otherwise EXEC.
  - EXEC:
    - R-type goes to WB.
    - LDUR and STUR go to MEM.
    - CBZ: pc <= zero ? branch_target : pc+4, retire, go to FETCH.
  - MEM: dmem_req=1, dmem_we=(STUR). On dmem_ack, LDUR goes to WB; STUR does pc+4, retires and goes to FETCH.
  - WB: reg_write=1 for exactly one cycle, mem_to_reg=(LDUR). Then pc+4, retire, go to FETCH.
  - HALT and FAULT are terminal until reset. halted or fault is held at 1 and no requests are issued.
- Control outputs are decoded from the state and the latched ir. They are valid from DECODE through the last phase and 0 in FETCH, HALT and FAULT.
  - reg_to_loc = STUR or CBZ.
  - alu_src = LDUR or STUR.
  - alu_op follows the class encoding above.
- Retire means instr_count increments by 1 (wraps 2^32-1 to 0).
- PC arithmetic is modulo 2^DATA_WIDTH. pc+4 wraps from all-ones-minus-3 to 0.
- ack is sampled only while the matching req is 1. An ack with req low is ignored.

## Timing
- Reset values: pc=RESET_PC, ir=0, instr_count=0, state=FETCH, and every other output 0. imem_req stays 0 while reset=1 and rises in the first cycle after reset deasserts.
- Cycles per instruction with zero-wait memories (ack in the first request cycle):
  - CBZ: 3.
  - R-type and STUR: 4.
  - LDUR: 5.
- Each memory wait cycle adds 1 cycle.
- req stays high continuously from state entry until the ack cycle, and drops in the cycle after ack.
- reset asserted mid-operation, including during a pending req, aborts the instruction with no retire and no reg_write. An ack arriving in the reset cycle is ignored.
- The PC, ir and instr_count are updated at the same clock edge as the state transition.

## Configuration
- MC_WATCHDOG_EN defined:
  - A wait counter clears on entry to FETCH or MEM and increments on every cycle without ack.
  - If it reaches MEM_TIMEOUT without an ack, the next state is FAULT.
  - If ack arrives in the same cycle the counter reaches MEM_TIMEOUT, ack wins.
- MC_WATCHDOG_EN undefined: no counter; waits are unbounded, and fault is raised only by an illegal opcode.

## Test plan
- Zero-wait memories, program ADD, SUB, ORR then 0: 4-cycle spacing per instruction, reg_write pulses 3 times, halted=1, instr_count=3, pc=RESET_PC+12.
- LDUR with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles, mem_to_reg=1 and reg_write=1 for one cycle, 8 cycles total.
- CBZ with zero=1 and branch_target=0x40: pc=0x40 after 3 cycles. With zero=0: pc=pc+4.
- Illegal word 32'hFFFF_FFFF: fault=1 in the cycle after DECODE, no requests afterwards, instr_count unchanged.
- Watchdog build, MEM_TIMEOUT=15, imem_ack never asserted: fault=1 after the 16th request cycle.
- Same stimulus with ack on wait cycle 15: no fault.
- reset pulsed during MEM of a STUR: outputs return to reset values and the dmem_ack in the reset cycle is ignored; the first fetch after reset starts at RESET_PC.
